rr_req_ack_arbiter: RTL and testbench

Round-robin arbiter that shares one req/ack data source among num_req requesters. Typical sources are a producer or an async_operator output stage. The block forwards one granted request upstream and waits for the source's single-cycle ack. It then returns the captured data word and a one-cycle ack pulse to the granted requester. It sits between a shared producer/operator output and several consumer-side req/ack ports in an arf netlist or testbench.

---
 rtl/rr_req_ack_arbiter.sv | 159 +++++++++++++++
 tb/tb_rr_req_ack_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_ack_arbiter.sv
// Round-robin arbiter sharing one req/ack data source among num_req requesters.
// One grant is forwarded upstream at a time; the captured word and a one-cycle ack return to the winner.
module rr_req_ack_arbiter #(
  parameter int num_req    = 4,
  parameter int data_width = 32,
  parameter int idx_width  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [num_req-1:0]    req_in,
  output logic [num_req-1:0]    ack_out,
  output logic [data_width-1:0] dout,
  output logic                  req_up,
  input  logic                  ack_up,
  input  logic [data_width-1:0] din_up,
  output logic [idx_width-1:0]  grant_idx,
  output logic                  busy,
  output logic [31:0]           xfer_count,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [idx_width-1:0]    ptr_q, ptr_d;
  logic                    req_up_q, req_up_d;
  logic [num_req-1:0]      ack_out_q, ack_out_d;
  logic [data_width-1:0]   dout_q, dout_d;
  logic [idx_width-1:0]    grant_idx_q, grant_idx_d;
  logic                    busy_q, busy_d;
  logic [31:0]             xfer_count_q, xfer_count_d;
  logic                    proto_err_q, proto_err_d;

  // Rotate requests so bit 0 of req_rot is the requester at ptr_q.
  logic [2*num_req-1:0]    req_dbl;
  logic [num_req-1:0]      req_rot;
  logic                    sel_valid;
  logic [idx_width-1:0]    sel_idx;
  int unsigned             sel_sum;
  logic [idx_width-1:0]    ptr_next;
  logic [num_req-1:0]      grant_onehot;

  assign req_dbl = {req_in, req_in};
  assign req_rot = req_dbl[ptr_q +: num_req];

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_sum   = 0;
    for (int k = num_req - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sel_valid = 1'b1;
        sel_sum   = int'(ptr_q) + k;
      end
    end
    if (sel_sum >= num_req) begin
      sel_sum = sel_sum - num_req;
    end
    sel_idx = idx_width'(sel_sum);
  end

  assign ptr_next = (grant_idx_q == idx_width'(num_req - 1)) ? '0 : grant_idx_q + 1'b1;

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < num_req; i++) begin
      grant_onehot[i] = (grant_idx_q == idx_width'(i));
    end
  end

  // State register and all output registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      req_up_q     <= 1'b0;
      ack_out_q    <= '0;
      // NOTE: dout is a single observable data register, not a memory, so it is reset along with the control state.
      dout_q       <= '0;
      grant_idx_q  <= '0;
      busy_q       <= 1'b0;
      xfer_count_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      req_up_q     <= req_up_d;
      ack_out_q    <= ack_out_d;
      dout_q       <= dout_d;
      grant_idx_q  <= grant_idx_d;
      busy_q       <= busy_d;
      xfer_count_q <= xfer_count_d;
      proto_err_q  <= proto_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (sel_valid) state_d = ST_WAIT;
      ST_WAIT:    if (ack_up) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    req_up_d     = req_up_q;
    ack_out_d    = '0;
    dout_d       = dout_q;
    grant_idx_d  = grant_idx_q;
    busy_d       = busy_q;
    xfer_count_d = xfer_count_q;
    proto_err_d  = proto_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_idx_d = sel_idx;
          req_up_d    = 1'b1;
          busy_d      = 1'b1;
        end
        if (ack_up) proto_err_d = 1'b1;
      end
      ST_WAIT: begin
        // req_in is deliberately ignored here: a dropped request still gets its ack.
        if (ack_up) begin
          dout_d       = din_up;
          ack_out_d    = grant_onehot;
          req_up_d     = 1'b0;
          ptr_d        = ptr_next;
          xfer_count_d = xfer_count_q + 32'd1;
        end
      end
      ST_RELEASE: begin
        busy_d = 1'b0;
        if (ack_up) proto_err_d = 1'b1;
      end
      default: begin
        req_up_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign ack_out    = ack_out_q;
  assign dout       = dout_q;
  assign req_up     = req_up_q;
  assign grant_idx  = grant_idx_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_count_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_rr_req_ack_arbiter.sv
// Directed bench for rr_req_ack_arbiter: grant order, data return, drop during wait,
// protocol errors and reset mid-transfer, with the upstream source driven inline.
module tb_rr_req_ack_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_in;
  logic [NR-1:0] ack_out;
  logic [DW-1:0] dout;
  logic          req_up;
  logic          ack_up;
  logic [DW-1:0] din_up;
  logic [IW-1:0] grant_idx;
  logic          busy;
  logic [31:0]   xfer_count;
  logic          proto_err;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  rr_req_ack_arbiter #(.num_req(NR), .data_width(DW), .idx_width(IW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out), .dout(dout),
    .req_up(req_up), .ack_up(ack_up), .din_up(din_up), .grant_idx(grant_idx),
    .busy(busy), .xfer_count(xfer_count), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req_up();
    int n = 0;
    while (req_up !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_up seen", 32'(req_up), 32'd1);
  endtask

  // Serve one upstream request after delay cycles and check the returned ack/data.
  task automatic transfer(input int exp_grant, input logic [31:0] data, input int delay,
                          input logic [31:0] exp_count);
    logic [NR-1:0] oh;
    oh = '0;
    oh[exp_grant] = 1'b1;
    wait_req_up();
    check("grant_idx", 32'(grant_idx), 32'(exp_grant));
    check("busy in wait", 32'(busy), 32'd1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("req_up held", 32'(req_up), 32'd1);
      check("grant frozen", 32'(grant_idx), 32'(exp_grant));
    end
    ack_up = 1'b1;
    din_up = data;
    @(negedge clk);
    ack_up = 1'b0;
    din_up = '0;
    check("ack_out pulse", 32'(ack_out), 32'(oh));
    check("dout", dout, data);
    check("xfer_count", xfer_count, exp_count);
    check("req_up drop", 32'(req_up), 32'd0);
    @(negedge clk);
    check("ack_out clear", 32'(ack_out), 32'd0);
    check("busy clear", 32'(busy), 32'd0);
    check("req_up gap", 32'(req_up), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    req_in = '0;
    ack_up = 1'b0;
    din_up = '0;
    do_reset();
    check("rst req_up", 32'(req_up), 32'd0);
    check("rst ack_out", 32'(ack_out), 32'd0);
    check("rst dout", dout, 32'd0);
    check("rst grant_idx", 32'(grant_idx), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst xfer_count", xfer_count, 32'd0);
    check("rst proto_err", 32'(proto_err), 32'd0);

    // Single requester 2, consecutive producer values.
    req_in = 4'b0100;
    @(negedge clk);
    check("t1 latency req_up", 32'(req_up), 32'd1);
    transfer(2, 32'd100, 0, 32'd1);
    transfer(2, 32'd101, 1, 32'd2);
    transfer(2, 32'd102, 2, 32'd3);

    // All requesters held from reset: 0,1,2,3,0.
    req_in = 4'b1111;
    do_reset();
    transfer(0, 32'd100, 0, 32'd1);
    transfer(1, 32'd101, 0, 32'd2);
    transfer(2, 32'd102, 0, 32'd3);
    transfer(3, 32'd103, 0, 32'd4);
    transfer(0, 32'd104, 0, 32'd5);

    // Pointer skip and wrap.
    req_in = 4'b0010;
    do_reset();
    transfer(1, 32'd10, 0, 32'd1);
    req_in = 4'b0001;
    transfer(0, 32'd11, 0, 32'd2);
    req_in = 4'b1001;
    transfer(3, 32'd12, 0, 32'd3);
    transfer(0, 32'd13, 0, 32'd4);

    // Granted requester drops its request during WAIT.
    req_in = '0;
    do_reset();
    req_in = 4'b0010;
    @(negedge clk);
    req_in = 4'b0000;
    transfer(1, 32'd55, 5, 32'd1);
    repeat (3) @(negedge clk);
    check("t4 idle busy", 32'(busy), 32'd0);
    check("t4 idle req_up", 32'(req_up), 32'd0);

    // Stray ack in IDLE.
    ack_up = 1'b1;
    din_up = 32'hDEAD;
    @(negedge clk);
    ack_up = 1'b0;
    din_up = '0;
    check("t5 proto_err set", 32'(proto_err), 32'd1);
    check("t5 dout kept", dout, 32'd55);
    check("t5 xfer kept", xfer_count, 32'd1);
    check("t5 ack_out quiet", 32'(ack_out), 32'd0);
    repeat (2) @(negedge clk);
    check("t5 proto_err sticky", 32'(proto_err), 32'd1);
    check("t5 ack_out still quiet", 32'(ack_out), 32'd0);
    do_reset();
    check("t5 proto_err cleared", 32'(proto_err), 32'd0);

    // Reset while in WAIT abandons the transfer and clears the pointer.
    req_in = 4'b0010;
    transfer(1, 32'd20, 0, 32'd1);
    wait_req_up();
    check("t6 grant before rst", 32'(grant_idx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 req_up", 32'(req_up), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 xfer_count", xfer_count, 32'd0);
    check("t6 grant_idx", 32'(grant_idx), 32'd0);
    check("t6 dout", dout, 32'd0);
    req_in = 4'b1000;
    transfer(3, 32'd77, 0, 32'd1);
    // Pointer now wrapped to 0: from {1,3} requester 1 wins.
    req_in = 4'b1010;
    transfer(1, 32'd78, 0, 32'd2);

    // Ack held for two cycles: one capture, then a protocol error.
    req_in = 4'b1000;
    wait_req_up();
    check("t7 grant", 32'(grant_idx), 32'd3);
    req_in = 4'b0000;
    ack_up = 1'b1;
    din_up = 32'd88;
    @(negedge clk);
    check("t7 ack_out", 32'(ack_out), 32'h8);
    check("t7 dout", dout, 32'd88);
    check("t7 xfer_count", xfer_count, 32'd3);
    check("t7 no err yet", 32'(proto_err), 32'd0);
    din_up = 32'd99;
    @(negedge clk);
    ack_up = 1'b0;
    din_up = '0;
    check("t7 proto_err", 32'(proto_err), 32'd1);
    check("t7 dout kept", dout, 32'd88);
    check("t7 xfer kept", xfer_count, 32'd3);
    check("t7 ack_out single", 32'(ack_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
